// File: rtl/fir_output_aligner_if.sv
// Handshake bundle between the FIR cascade tail and the result consumer.
// The block drives the output side through the slave modport.
interface fir_output_aligner_if #(
  parameter int DATA_W     = 48,
  parameter int FIFO_DEPTH = 8
);
  logic                               in_valid;
  logic [DATA_W-1:0]                  acc_in;
  logic                               flush;
  logic                               out_ready;
  logic                               out_valid;
  logic [DATA_W-1:0]                  out_data;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    level;
  logic                               overflow;
  logic [1:0]                         state;

  modport master (
    output in_valid, acc_in, flush, out_ready,
    input  out_valid, out_data, level, overflow, state
  );

  modport slave (
    input  in_valid, acc_in, flush, out_ready,
    output out_valid, out_data, level, overflow, state
  );
endinterface

// File: rtl/fir_output_aligner.sv
// Aligns DSP58 cascade results to their input samples, drops the partial sums
// produced while the tap line fills, and buffers full-length results in a FIFO.
module fir_output_aligner #(
  parameter int DSP_LATENCY   = 4,
  parameter int FILTER_LENGTH = 16,
  parameter int DATA_W        = 48,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fir_output_aligner_if.slave   bus
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = $clog2(FILTER_LENGTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic [DSP_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [CNT_W-1:0]       fill_cnt_q, fill_cnt_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   ovf_q, ovf_d;
  logic [DATA_W-1:0]      out_data_q, out_data_d;
  logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];

  logic tap_valid, push, pop, full, wr_en;

  assign tap_valid = vld_pipe_q[DSP_LATENCY-1];

  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    push       = 1'b0;
    vld_pipe_d[0] = bus.in_valid;
    for (int i = 1; i < DSP_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    case (state_q)
      IDLE: if (tap_valid) begin
        fill_cnt_d = CNT_W'(1);
        if (FILTER_LENGTH == 1) begin
          state_d = RUN;
          push    = 1'b1;
        end else begin
          state_d = FILL;
        end
      end
      FILL: if (tap_valid) begin
        fill_cnt_d = fill_cnt_q + CNT_W'(1);
        // The tap that completes the delay line is the first full-length result.
        if (fill_cnt_q == CNT_W'(FILTER_LENGTH - 1)) begin
          state_d = RUN;
          push    = 1'b1;
        end
      end
      RUN:     push = tap_valid;
      default: state_d = IDLE;
    endcase

    full  = (level_q == LVL_W'(FIFO_DEPTH));
    pop   = (level_q != '0) && bus.out_ready;
    wr_en = push && (!full || pop);

    wr_ptr_d = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    level_d  = level_q + LVL_W'(wr_en) - LVL_W'(pop);
    ovf_d    = ovf_q | (push && full && !pop);

    // Next head may be the slot being written this very cycle.
    if (level_d == '0)                       out_data_d = '0;
    else if (wr_en && (rd_ptr_d == wr_ptr_q)) out_data_d = bus.acc_in;
    else                                      out_data_d = mem_q[rd_ptr_d];

    if (bus.flush) begin
      state_d    = IDLE;
      fill_cnt_d = '0;
      vld_pipe_d = '0;
      wr_en      = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      ovf_d      = 1'b0;
      out_data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vld_pipe_q <= '0;
      fill_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      vld_pipe_q <= vld_pipe_d;
      fill_cnt_q <= fill_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= bus.acc_in;
  end

  assign bus.out_valid = (level_q != '0);
  assign bus.out_data  = out_data_q;
  assign bus.level     = level_q;
  assign bus.overflow  = ovf_q;
  assign bus.state     = state_q;
endmodule

// File: tb/tb_fir_output_aligner.sv
// Directed bench for fir_output_aligner at DSP_LATENCY=4, FILTER_LENGTH=16, FIFO_DEPTH=8.
module tb_fir_output_aligner;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   expq[$];

  always #5 clk = ~clk;

  fir_output_aligner_if #(.DATA_W(48), .FIFO_DEPTH(8)) bus ();

  fir_output_aligner #(
    .DSP_LATENCY(4), .FILTER_LENGTH(16), .DATA_W(48), .FIFO_DEPTH(8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid  = 1'b0;
    bus.acc_in    = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_flush();
    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  // n samples; acc_in ramps base+i so the tap for sample i sees base+i+4.
  task automatic feed(input int n, input int base);
    for (int i = 0; i < n + 5; i++) begin
      @(negedge clk);
      bus.in_valid = (i < n);
      bus.acc_in   = 48'(base + i);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && expq.size() > 0; c++) begin
      if (bus.out_valid) begin
        total++;
        if (bus.out_data !== 48'(expq[0])) begin
          bad++;
          $display("FAIL %s got=%0d exp=%0d", name, bus.out_data, expq[0]);
        end
        void'(expq.pop_front());
      end
      @(negedge clk);
    end
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL %s_timeout remaining=%0d exp=0", name, expq.size());
      expq.delete();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'($urandom);
    bus.acc_in    = {$urandom, $urandom};
    bus.flush     = 1'($urandom);
    bus.out_ready = 1'($urandom);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_overflow", bus.overflow, 0);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
  endtask

  task automatic test_fill_and_run();
    int nout = 0;
    int first = -1;
    do_reset();
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (cyc == 4)  chk("idle_at_4", bus.state, 0);
      if (cyc == 5)  chk("fill_at_5", bus.state, 1);
      if (cyc == 19) chk("fill_at_19", bus.state, 1);
      if (cyc == 20) chk("run_at_20", bus.state, 2);
      if (cyc == 20) chk("level_push_pop_empty", bus.level, 1);
      if (bus.out_valid) begin
        if (first < 0) first = cyc;
        chk("run_out_data", bus.out_data, 19 + nout);
        nout++;
      end
      bus.in_valid = (cyc <= 19);
      bus.acc_in   = 48'(cyc);
    end
    chk("first_valid_cycle", first, 20);
    chk("output_count", nout, 5);
    chk("no_overflow", bus.overflow, 0);
    chk("drained_level", bus.level, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    do_flush();
    bus.out_ready = 1'b0;
    feed(35, 100);
    chk("ovf_level", bus.level, 8);
    chk("ovf_sticky", bus.overflow, 1);
    chk("ovf_head_stable", bus.out_data, 119);
    for (int v = 119; v <= 126; v++) expq.push_back(v);
    drain("ovf_drain");
    chk("ovf_level_empty", bus.level, 0);
    chk("ovf_valid_empty", bus.out_valid, 0);
    chk("ovf_still_set", bus.overflow, 1);
  endtask

  task automatic test_full_push_pop();
    do_flush();
    chk("flush_clears_ovf", bus.overflow, 0);
    feed(23, 200);
    chk("full_level", bus.level, 8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid  = (i == 0);
      bus.out_ready = (i == 4);
      bus.acc_in    = (i == 4) ? 48'd300 : 48'd0;
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("full_pp_level", bus.level, 8);
    chk("full_pp_ovf", bus.overflow, 0);
    chk("full_pp_head", bus.out_data, 220);
    for (int v = 220; v <= 226; v++) expq.push_back(v);
    expq.push_back(300);
    drain("full_pp_drain");
    chk("full_pp_empty", bus.level, 0);
  endtask

  task automatic test_flush_refill();
    do_flush();
    feed(10, 0);
    chk("pre_flush_state", bus.state, 1);
    do_flush();
    chk("flush_state", bus.state, 0);
    chk("flush_level", bus.level, 0);
    feed(15, 400);
    chk("refill15_level", bus.level, 0);
    chk("refill15_state", bus.state, 1);
    feed(1, 500);
    chk("refill16_level", bus.level, 1);
    chk("refill16_data", bus.out_data, 504);
    chk("refill16_state", bus.state, 2);
  endtask

  task automatic test_reset_mid_run();
    do_flush();
    feed(20, 600);
    chk("mid_level5", bus.level, 5);
    chk("mid_run", bus.state, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    chk("mid_rst_state", bus.state, 0);
    chk("mid_rst_level", bus.level, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    feed(15, 700);
    chk("post_rst15_level", bus.level, 0);
    chk("post_rst15_state", bus.state, 1);
    feed(1, 800);
    chk("post_rst16_level", bus.level, 1);
    chk("post_rst16_data", bus.out_data, 804);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_and_run();
    test_overflow();
    test_full_push_pop();
    test_flush_refill();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fir_output_aligner.md
FIR_OUTPUT_ALIGNER -- requirements
Module: fir_output_aligner

Interface
REQ-001 SHALL have parameter DSP_LATENCY, default 4, giving the cycles from a sample entering the DSP58 cascade to its result at the cascade output.
REQ-002 SHALL have parameter FILTER_LENGTH, default 16, giving the tap count; results before the delay line is full are partial sums.
REQ-003 SHALL have parameter DATA_W, default 48, giving the accumulator/result width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, giving the output buffer entries (power of 2, >=2).
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  a sample enters the filter this cycle.
REQ-008 acc_in  input  DATA_W  cascade output of the last DSP58 stage.
REQ-009 flush  input  1  synchronous restart of alignment and buffer.
REQ-010 out_ready  input  1  downstream accepts out_data this cycle.
REQ-011 out_valid  output  1  out_data holds a valid full-length result.
REQ-012 out_data  output  DATA_W  oldest buffered result.
REQ-013 level  output  $clog2(FIFO_DEPTH+1)  buffered entry count.
REQ-014 overflow  output  1  sticky; a full-length result was dropped.
REQ-015 state  output  2  FSM state: IDLE=0, FILL=1, RUN=2.

Function
REQ-016 SHALL delay in_valid through a DSP_LATENCY-stage shift register; the last stage is tap_valid, and acc_in is sampled only when tap_valid=1 (result for in_valid at cycle t is sampled at t+DSP_LATENCY).
REQ-017 SHALL count tap_valid events in fill_cnt while in IDLE or FILL; the first FILTER_LENGTH-1 events are discarded, never buffered.
REQ-018 IDLE->FILL on the first tap_valid; FILL->RUN on the tap_valid making the count FILTER_LENGTH; that result is the first pushed, in the same cycle; FILTER_LENGTH=1 goes IDLE->RUN with push.
REQ-019 In RUN every tap_valid SHALL push acc_in; RUN is left only by flush or reset.
REQ-020 SHALL implement the buffer as a FIFO with wrap-around read/write pointers; out_valid = (level!=0); out_data = head entry, registered.
REQ-021 A pop occurs when out_valid && out_ready; out_data and out_valid SHALL be stable while out_valid && !out_ready.
REQ-022 Latency: a result pushed at cycle c SHALL be visible at out_data with out_valid=1 at cycle c+1 when the FIFO was empty.
REQ-023 Push when full SHALL be accepted only if a pop occurs the same cycle (level unchanged); otherwise the result is dropped, FIFO unchanged, overflow set to 1.
REQ-024 Pop when empty SHALL have no effect; simultaneous push and pop on an empty FIFO leaves level 1 (pop ignored).
REQ-025 flush=1 SHALL, next edge, clear the shift register, fill_cnt, FIFO pointers, level and overflow, set state IDLE; flush overrides same-cycle push, pop and in_valid.
REQ-026 Results SHALL leave in push order, unmodified, with no arithmetic on acc_in.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_data=0, level=0, overflow=0, fill_cnt=0, shift register 0, pointers 0, regardless of clk.
REQ-028 Reset mid-operation SHALL discard all buffered and in-flight results; after release the block behaves as from power-up.
REQ-029 First capture after deassertion SHALL occur on the first rising clk edge with rst_n=1.

Verification (DSP_LATENCY=4, FILTER_LENGTH=16, FIFO_DEPTH=8)
REQ-030 Assert rst_n=0 with random inputs -> all outputs 0, state=IDLE, without a clk edge.
REQ-031 in_valid=1 cycles 0..19, acc_in=cycle number, out_ready=1 -> state FILL at 5, RUN at 20, out_valid first at 20 with out_data=19, exactly 5 outputs 19..23, overflow=0.
REQ-032 out_ready=0, 20 RUN results -> level saturates at 8, overflow=1, 12 dropped; then out_ready=1 -> first 8 values drained in order, level returns to 0, overflow remains 1.
REQ-033 Full FIFO, out_ready=1 and tap_valid in same cycle -> level stays 8, overflow stays 0, ordering preserved.
REQ-034 flush after 10 fill results -> state=IDLE, level=0; next 15 results discarded, 16th pushed.
REQ-035 rst_n pulsed low mid-RUN with level=5 -> outputs cleared asynchronously; refill requires 15 new discarded results.
